mem_stage_ls: RTL

//  Parametrised MEM pipeline stage for the 5-stage CPU. Sits between EXE and WB.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/mem_load_align.sv | 30 +++
 rtl/mem_stage_ls.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: load-op encodings, bus widths and field offsets.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Used by EXE, MEM and WB so that every stage slices the inter-stage buses identically.
package cpu_pkg;

    // ld_op encodings; 5..7 are unused and behave as a full-word load
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // exe_mem_bus = {gr_we, res_from_mem, mem_req, ld_op[2:0], dest, pc, inst, alu_result}
    function automatic int in_w(input int reg_aw, input int data_w);
        return 70 + reg_aw + data_w;
    endfunction

    // mem_wb_bus = {gr_we, pc, inst, final_result, dest}
    function automatic int out_w(input int reg_aw, input int data_w);
        return 65 + reg_aw + data_w;
    endfunction

    // mem_fwd_bus = {fwd_en, fwd_stall, dest, final_result}
    function automatic int fwd_w(input int reg_aw, input int data_w);
        return 2 + reg_aw + data_w;
    endfunction

    // exe_mem_bus field LSB positions
    function automatic int in_inst_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int in_pc_lsb(input int data_w);
        return data_w + 32;
    endfunction

    function automatic int in_dest_lsb(input int data_w);
        return data_w + 64;
    endfunction

    function automatic int in_ldop_lsb(input int reg_aw, input int data_w);
        return data_w + 64 + reg_aw;
    endfunction

    function automatic int in_req_bit(input int reg_aw, input int data_w);
        return data_w + 67 + reg_aw;
    endfunction

    function automatic int in_rfm_bit(input int reg_aw, input int data_w);
        return data_w + 68 + reg_aw;
    endfunction

    function automatic int in_grwe_bit(input int reg_aw, input int data_w);
        return data_w + 69 + reg_aw;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: shifts the SRAM word by the byte offset and sign/zero-extends per ld_op.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: rdata (raw word), offset (byte address bits [1:0]), ld_op (load type) -> data (extended result).
module mem_load_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        ld_op,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (ld_op)
            LD_B:    data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            LD_BU:   data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            LD_H:    data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            LD_HU:   data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data, drives WB and forwarding.
// Latency: 0 cycles beyond SRAM response latency (data_ok with wb_allowin passes straight through).
// Backpressure: valid/allowin handshake; a response arriving while WB stalls is held in a one-entry buffer.
// Ports: clk/reset, flush, exe_mem_valid/mem_allowin/exe_mem_bus from EXE,
//        mem_wb_valid/wb_allowin/mem_wb_bus to WB, data_sram_data_ok/rdata, mem_fwd_bus to ID.
module mem_stage_ls
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MAX_DISCARD = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  exe_mem_valid,
    output logic                                  mem_allowin,
    output logic                                  mem_wb_valid,
    input  logic                                  wb_allowin,
    input  logic [in_w(REG_AW, DATA_W)-1:0]       exe_mem_bus,
    input  logic                                  data_sram_data_ok,
    input  logic [DATA_W-1:0]                     data_sram_rdata,
    output logic [out_w(REG_AW, DATA_W)-1:0]      mem_wb_bus,
    output logic [fwd_w(REG_AW, DATA_W)-1:0]      mem_fwd_bus
);

    localparam int IN_W      = in_w(REG_AW, DATA_W);
    localparam int INST_LSB  = in_inst_lsb(DATA_W);
    localparam int PC_LSB    = in_pc_lsb(DATA_W);
    localparam int DEST_LSB  = in_dest_lsb(DATA_W);
    localparam int LDOP_LSB  = in_ldop_lsb(REG_AW, DATA_W);
    localparam int REQ_BIT   = in_req_bit(REG_AW, DATA_W);
    localparam int RFM_BIT   = in_rfm_bit(REG_AW, DATA_W);
    localparam int GRWE_BIT  = in_grwe_bit(REG_AW, DATA_W);
    localparam int CNT_W     = $clog2(MAX_DISCARD + 1);
    localparam logic [CNT_W-1:0] DISC_MAX = CNT_W'(MAX_DISCARD);

    logic                mem_valid;
    logic                buf_valid;
    logic [DATA_W-1:0]   buf_dat;
    logic [IN_W-1:0]     in_bus;
    logic [CNT_W-1:0]    discard_cnt;

    logic                gr_we, res_from_mem, mem_req;
    logic [2:0]          ld_op;
    logic [REG_AW-1:0]   dest;
    logic [31:0]         pc, inst;
    logic [DATA_W-1:0]   alu_result;

    logic                got_resp, drop_resp, mem_ready_go, disc_inc, buf_capture;
    logic [DATA_W-1:0]   ld_raw, ld_ext, final_result;

    assign gr_we        = in_bus[GRWE_BIT];
    assign res_from_mem = in_bus[RFM_BIT];
    assign mem_req      = in_bus[REQ_BIT];
    assign ld_op        = in_bus[LDOP_LSB +: 3];
    assign dest         = in_bus[DEST_LSB +: REG_AW];
    assign pc           = in_bus[PC_LSB +: 32];
    assign inst         = in_bus[INST_LSB +: 32];
    assign alu_result   = in_bus[DATA_W-1:0];

    // Responses owed to flushed instructions arrive first (in-order SRAM) and are swallowed here.
    assign got_resp     = data_sram_data_ok & (discard_cnt == '0);
    assign drop_resp    = data_sram_data_ok & (discard_cnt != '0);
    assign mem_ready_go = ~mem_req | buf_valid | got_resp;
    assign mem_wb_valid = mem_valid & mem_ready_go & ~flush;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);

    // A dying entry whose response is still outstanding leaves one response to drop.
    // If the response lands in the flush cycle it is consumed by the dying entry instead.
    assign disc_inc     = flush & mem_valid & mem_req & ~buf_valid & ~got_resp;
    assign buf_capture  = mem_valid & mem_req & got_resp & ~buf_valid & ~wb_allowin;

    assign ld_raw = buf_valid ? buf_dat : data_sram_rdata;

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata  (ld_raw),
        .offset (alu_result[1:0]),
        .ld_op  (ld_op),
        .data   (ld_ext)
    );

    assign final_result = res_from_mem ? ld_ext : alu_result;
    assign mem_wb_bus   = {gr_we, pc, inst, final_result, dest};
    assign mem_fwd_bus  = {mem_valid & gr_we,
                           mem_valid & res_from_mem & ~mem_ready_go,
                           dest, final_result};

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            buf_valid <= 1'b0;
        end else if (flush) begin
            mem_valid <= 1'b0;
            buf_valid <= 1'b0;
        end else if (mem_allowin) begin
            // Entry leaves or is replaced: buffered data belongs to the old entry.
            mem_valid <= exe_mem_valid;
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            buf_valid <= 1'b1;
        end
    end

    // Payload registers carry no reset; they are qualified by mem_valid/buf_valid.
    always_ff @(posedge clk) begin
        if (exe_mem_valid && mem_allowin) begin
            in_bus <= exe_mem_bus;
        end
        if (buf_capture) begin
            buf_dat <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else begin
            case ({disc_inc, drop_resp})
                2'b10:   if (discard_cnt != DISC_MAX) discard_cnt <= discard_cnt + 1'b1;
                2'b01:   discard_cnt <= discard_cnt - 1'b1;
                default: discard_cnt <= discard_cnt;
            endcase
        end
    end

endmodule
